// File: rtl/window_3x3_gen_pkg.sv
// Shared word width and default image geometry for the 3x3 window
// generator and the FP32 averaging pipeline it feeds.
package window_3x3_gen_pkg;

    localparam int DATA_W    = 32;
    localparam int IMG_W_DEF = 64;
    localparam int IMG_H_DEF = 64;
    localparam int WIN_N     = 9;

    typedef logic [DATA_W-1:0] pix_t;

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel stream in, 3x3 window out; master is the pixel source,
// slave is the window generator.
interface window_3x3_gen_if;
    import window_3x3_gen_pkg::*;

    logic pixel_valid;
    logic frame_start;
    pix_t pixel_in;
    logic output_valid;
    logic frame_done;
    pix_t OUT_1, OUT_2, OUT_3;
    pix_t OUT_4, OUT_5, OUT_6;
    pix_t OUT_7, OUT_8, OUT_9;

    modport master (
        output pixel_valid, frame_start, pixel_in,
        input  output_valid, frame_done,
        input  OUT_1, OUT_2, OUT_3,
        input  OUT_4, OUT_5, OUT_6,
        input  OUT_7, OUT_8, OUT_9
    );

    modport slave (
        input  pixel_valid, frame_start, pixel_in,
        output output_valid, frame_done,
        output OUT_1, OUT_2, OUT_3,
        output OUT_4, OUT_5, OUT_6,
        output OUT_7, OUT_8, OUT_9
    );

endinterface

// File: rtl/window_3x3_gen_line_buffer.sv
// One image row of storage; the read port sees the old word at the
// same address being written (read-before-write).
module line_buffer #(
    parameter  int DEPTH = 64,
    parameter  int W     = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 window generator: two chained line buffers plus a
// 3x3 shift window, valid once the window lies inside the image.
module window_3x3_gen
    import window_3x3_gen_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input logic             clk,
    input logic             rst,
    window_3x3_gen_if.slave bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] r_col, w_col, w_col_nxt;
    logic [RW-1:0] r_row, w_row, w_row_nxt;
    logic          w_col_last, w_row_last, w_in_img;
    pix_t          w_l1, w_l2;
    pix_t          r_win [WIN_N];
    logic          r_ov, r_fd;

    // frame_start overrides the counters for the pixel it marks
    always_comb begin
        w_col      = bus.frame_start ? '0 : r_col;
        w_row      = bus.frame_start ? '0 : r_row;
        w_col_last = (w_col == C_LAST);
        w_row_last = (w_row == R_LAST);
        w_col_nxt  = w_col_last ? '0 : w_col + 1'b1;
        w_row_nxt  = w_row;
        if (w_col_last) w_row_nxt = w_row_last ? '0 : w_row + 1'b1;
        w_in_img   = (w_row >= RW'(2)) && (w_col >= CW'(2));
    end

    line_buffer #(.DEPTH(IMG_W), .W(DATA_W)) u_line1 (
        .clk     (clk),
        .i_en    (bus.pixel_valid),
        .i_addr  (w_col),
        .i_wdata (bus.pixel_in),
        .o_rdata (w_l1)
    );

    line_buffer #(.DEPTH(IMG_W), .W(DATA_W)) u_line2 (
        .clk     (clk),
        .i_en    (bus.pixel_valid),
        .i_addr  (w_col),
        .i_wdata (w_l1),
        .o_rdata (w_l2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (bus.pixel_valid) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < WIN_N; k++) r_win[k] <= '0;
        end else if (bus.pixel_valid) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= w_l2;
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= w_l1;
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= bus.pixel_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ov <= 1'b0;
            r_fd <= 1'b0;
        end else begin
            r_ov <= bus.pixel_valid && w_in_img;
            r_fd <= bus.pixel_valid && w_row_last && w_col_last;
        end
    end

    assign bus.output_valid = r_ov;
    assign bus.frame_done   = r_fd;
    assign bus.OUT_1 = r_win[0];
    assign bus.OUT_2 = r_win[1];
    assign bus.OUT_3 = r_win[2];
    assign bus.OUT_4 = r_win[3];
    assign bus.OUT_5 = r_win[4];
    assign bus.OUT_6 = r_win[5];
    assign bus.OUT_7 = r_win[6];
    assign bus.OUT_8 = r_win[7];
    assign bus.OUT_9 = r_win[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x4 image.
module tb_window_3x3_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    window_3x3_gen_if intf ();

    window_3x3_gen #(.IMG_W(4), .IMG_H(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf)
    );

    typedef struct {
        logic        v;
        logic        fs;
        logic [31:0] px;
        logic        ov;
        logic        fd;
        logic        cw;
        int          w [9];
    } vec_t;

    vec_t tbl [17];

    function automatic logic [31:0] outk(int k);
        case (k)
            0: return intf.OUT_1;
            1: return intf.OUT_2;
            2: return intf.OUT_3;
            3: return intf.OUT_4;
            4: return intf.OUT_5;
            5: return intf.OUT_6;
            6: return intf.OUT_7;
            7: return intf.OUT_8;
            default: return intf.OUT_9;
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_ov"}, 32'(intf.output_valid), 32'd0);
        chk({nm, "_fd"}, 32'(intf.frame_done), 32'd0);
        for (int k = 0; k < 9; k++)
            chk($sformatf("%s_out%0d", nm, k + 1), outk(k), 32'd0);
    endtask

    // 16-pixel 4x4 frame; expected window built from row/col geometry
    task automatic run_stream(input logic [31:0] base, input bit bub,
                              input bit fs, input bit cst, input string nm);
        int nv = 0;
        for (int p = 0; p < 16; p++) begin
            int r = p / 4;
            int c = p % 4;
            bit ev = (r >= 2) && (c >= 2);
            @(negedge clk);
            intf.pixel_valid = 1'b1;
            intf.frame_start = fs && (p == 0);
            intf.pixel_in    = cst ? base : base + 32'(p);
            @(posedge clk);
            #1;
            chk($sformatf("%s_ov_p%0d", nm, p), 32'(intf.output_valid), 32'(ev));
            chk($sformatf("%s_fd_p%0d", nm, p), 32'(intf.frame_done), 32'(p == 15));
            if (ev) begin
                nv++;
                for (int k = 0; k < 9; k++) begin
                    int idx = (r - 2 + k / 3) * 4 + (c - 2 + k % 3);
                    chk($sformatf("%s_p%0d_out%0d", nm, p, k + 1), outk(k),
                        cst ? base : base + 32'(idx));
                end
            end
            if (bub) begin
                @(negedge clk);
                intf.pixel_valid = 1'b0;
                intf.frame_start = 1'b0;
                @(posedge clk);
                #1;
                chk($sformatf("%s_bub_ov%0d", nm, p), 32'(intf.output_valid), 32'd0);
                chk($sformatf("%s_bub_fd%0d", nm, p), 32'(intf.frame_done), 32'd0);
            end
        end
        intf.pixel_valid = 1'b0;
        intf.frame_start = 1'b0;
        chk({nm, "_nvalid"}, 32'(nv), 32'd4);
    endtask

    initial begin
        intf.pixel_valid = 1'b0;
        intf.frame_start = 1'b0;
        intf.pixel_in    = '0;

        for (int i = 0; i < 16; i++) begin
            tbl[i].v  = 1'b1;
            tbl[i].fs = (i == 0);
            tbl[i].px = 32'(i);
            tbl[i].ov = 1'b0;
            tbl[i].fd = 1'b0;
            tbl[i].cw = 1'b0;
            tbl[i].w  = '{default: 0};
        end
        tbl[10].ov = 1'b1; tbl[10].cw = 1'b1;
        tbl[10].w  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        tbl[11].ov = 1'b1; tbl[11].cw = 1'b1;
        tbl[11].w  = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        tbl[14].ov = 1'b1; tbl[14].cw = 1'b1;
        tbl[14].w  = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
        tbl[15].ov = 1'b1; tbl[15].cw = 1'b1; tbl[15].fd = 1'b1;
        tbl[15].w  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        tbl[16].v  = 1'b0; tbl[16].fs = 1'b0; tbl[16].px = 32'd99;
        tbl[16].ov = 1'b0; tbl[16].fd = 1'b0; tbl[16].cw = 1'b1;
        tbl[16].w  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

        // reset state
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // scenario 1: continuous frame from table
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            intf.pixel_valid = tbl[i].v;
            intf.frame_start = tbl[i].fs;
            intf.pixel_in    = tbl[i].px;
            @(posedge clk);
            #1;
            chk($sformatf("t%0d_ov", i), 32'(intf.output_valid), 32'(tbl[i].ov));
            chk($sformatf("t%0d_fd", i), 32'(intf.frame_done), 32'(tbl[i].fd));
            if (tbl[i].cw)
                for (int k = 0; k < 9; k++)
                    chk($sformatf("t%0d_out%0d", i, k + 1), outk(k),
                        32'(tbl[i].w[k]));
        end
        intf.pixel_valid = 1'b0;

        // scenario 2: bubbles between every pixel
        run_stream(32'd0, 1'b1, 1'b1, 1'b0, "bub");

        // scenario 3: back-to-back frames, frame_start on first only
        run_stream(32'd0, 1'b0, 1'b1, 1'b0, "f1");
        run_stream(32'd100, 1'b0, 1'b0, 1'b0, "f2");

        // scenario 4: frame_start after 6 stray pixels
        for (int p = 0; p < 6; p++) begin
            @(negedge clk);
            intf.pixel_valid = 1'b1;
            intf.frame_start = 1'b0;
            intf.pixel_in    = 32'd50 + 32'(p);
            @(posedge clk);
            #1;
            chk($sformatf("pre_ov%0d", p), 32'(intf.output_valid), 32'd0);
        end
        run_stream(32'd200, 1'b0, 1'b1, 1'b0, "mid");

        // scenario 5: reset after pixel 9
        for (int p = 0; p < 10; p++) begin
            @(negedge clk);
            intf.pixel_valid = 1'b1;
            intf.frame_start = (p == 0);
            intf.pixel_in    = 32'd400 + 32'(p);
        end
        @(negedge clk);
        intf.pixel_valid = 1'b0;
        intf.frame_start = 1'b0;
        rst = 1'b1;
        #1;
        chk_zero("rst_in");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("rst_after");
        run_stream(32'd300, 1'b0, 1'b0, 1'b0, "post");

        // scenario 6: constant 1.0 frame
        run_stream(32'h3F800000, 1'b0, 1'b1, 1'b1, "one");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Streaming 3x3 window generator that feeds the 9-input FP32 averaging pipeline (its IN_1..IN_9 / input_valid side).
- Accepts raster-order 32-bit pixels, one per cycle when valid, and stores the two previous image rows in line buffers.
- Emits one fully-populated 3x3 window per accepted pixel once the window lies entirely inside the image. No padding is applied.
- Data is opaque 32-bit (FP32 bit patterns pass through untouched).

Parameters:
- DATA_W, 32, pixel/word width
- IMG_W, 64, pixels per row (>=3)
- IMG_H, 64, rows per frame (>=3)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- pixel_valid  input  1  pixel_in is valid this cycle; accepted unconditionally (no backpressure)
- frame_start  input  1  qualified by pixel_valid; marks this pixel as (row 0, col 0)
- pixel_in  input  DATA_W  raster-order pixel
- output_valid  output  1  OUT_1..OUT_9 hold a valid window this cycle
- OUT_1..OUT_9  output  DATA_W each  window, row-major; OUT_1 is top-left, OUT_5 is centre, OUT_9 is bottom-right (the newest pixel)
- frame_done  output  1  one-cycle pulse, registered with the last pixel of the frame

Behaviour:
- Reset (async, rst=1):
  - col/row counters = 0.
  - Window registers, OUT_1..OUT_9 = 0.
  - output_valid = 0, frame_done = 0.
  - Line-buffer contents are don't-care; row gating prevents their use.
- Accepted pixel: pixel_valid=1 at position (r,c), where c = column counter and r = row counter; if frame_start=1, r=c=0 regardless of counter values. On that edge:
  - Read line1[c] (value from row r-1) and line2[c] (value from row r-2), read-before-write.
  - Write line2[c] <= line1[c] and line1[c] <= pixel_in.
  - Shift the window one column left. The new right column is {line2[c], line1[c], pixel_in} → OUT_3, OUT_6, OUT_9.
  - output_valid <= (r>=2 && c>=2).
  - frame_done <= (r==IMG_H-1 && c==IMG_W-1).
- Latency: window for pixel (r,c) appears 1 cycle after that pixel's accepting edge, i.e. OUT_9 = pixel(r,c) and OUT_1 = pixel(r-2,c-2).
- Counters:
  - c increments per accepted pixel and wraps IMG_W-1 → 0, incrementing r.
  - r wraps IMG_H-1 → 0 on the final pixel.
  - The next frame starts automatically without frame_start.
- pixel_valid=0: counters, line buffers and window hold. output_valid <= 0 and frame_done <= 0 next cycle. OUT_x hold their last values.
- Row-start columns c=0,1 shift stale data from the previous row into the window. This is masked by output_valid=0. By c=2 the window holds only current-row columns.
- frame_start mid-frame: counters are forced to (0,0) for that pixel. The rows above are treated as invalid because of r gating, so there is no corruption.
- Windows per frame: (IMG_W-2)*(IMG_H-2). Outputs are not held beyond one cycle; the downstream pipeline consumes every valid cycle.
- Counter widths: $clog2(IMG_W) and $clog2(IMG_H).

Decomposition:
- Shared header holds DATA_W and default image dimensions, so they are shared with the averaging pipeline.
- One sub-module, line_buffer: depth IMG_W, width DATA_W, read-before-write at the same address, enable-gated.
  - Two instances are used, chained (line1 output feeds the line2 write data).

Test Plan:
1. IMG_W=IMG_H=4, pixels 0..15 continuous with frame_start on pixel 0:
   - Expect output_valid high the cycle after pixels 10, 11, 14 and 15.
   - First window is 0,1,2,4,5,6,8,9,10; last is 5,6,7,9,10,11,13,14,15.
   - frame_done pulses once, coincident with the last window.
2. Same frame with pixel_valid=0 bubbles inserted between every pixel:
   - Windows are identical to scenario 1.
   - output_valid is never high in bubble-following cycles.
   - Exactly 4 valid cycles occur.
3. Two back-to-back frames (values 0..15, then 100..115), frame_start on the first only:
   - Second frame's first window is 100,101,102,104,105,106,108,109,110.
   - No window mixes the two frames.
4. frame_start asserted at pixel 6 of a frame, then 16 pixels 200..215:
   - The first 6 pixels are ignored.
   - First valid window is 200,201,202,204,205,206,208,209,210.
5. rst pulse mid-frame after pixel 9:
   - All outputs are 0 during and after reset.
   - No output_valid until a fresh frame reaches row 2, column 2.
6. Connect to the averaging pipeline, with all pixels 0x3F800000 (1.0):
   - Every averaged result is approximately 0x3F800000, within 1 ULP.
   - The valid count equals (IMG_W-2)*(IMG_H-2).
